// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } arb_state_t;

  localparam int CNT_W = 20;

  function automatic int bit_cyc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request after i_ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_pick,
  output logic [IDX_W-1:0] o_idx
);

  int w_cand;

  // Walk from farthest to nearest so the candidate closest to ptr+1 is written last.
  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    w_cand = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = (int'(i_ptr) + k) % NREQ;
      if (i_req[w_cand]) begin
        o_pick         = '0;
        o_pick[w_cand] = 1'b1;
        o_idx          = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one byte serialiser, with a
// post-packet idle gap and a per-byte completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATA_W   = 8,
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 10,
  parameter int TMO_BITS = 12
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DATA_W-1:0] i_req_data,
  input  logic [NREQ-1:0]        i_req_last,
  output logic [NREQ-1:0]        o_req_ack,
  output logic [NREQ-1:0]        o_grant,
  output logic                   o_tx_start,
  output logic [DATA_W-1:0]      o_tx_data,
  input  logic                   i_tx_busy,
  input  logic                   i_tx_done,
  output logic                   o_err_tmo,
  output logic                   o_active
);

  localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam int GAP_CYC = GAP_BITS * BIT_CYC;
  localparam int TMO_CYC = TMO_BITS * BIT_CYC;
  localparam int IDX_W   = $clog2(NREQ);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

  if ($clog2(TMO_CYC) > CNT_W || $clog2(GAP_CYC) > CNT_W) begin : g_cnt_range
    $error("cycle count does not fit the 20-bit counter");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_range
    $error("NREQ must be in 2..8");
  end

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [NREQ-1:0]    r_grant;
  logic [NREQ-1:0]    r_ack;
  logic               r_start;
  logic [DATA_W-1:0]  r_data;
  logic               r_last;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [NREQ-1:0]    w_pick;
  logic [IDX_W-1:0]   w_idx;
  logic               w_owner_req;
  logic [DATA_W-1:0]  w_owner_data;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req  (i_req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx)
  );

  // r_ptr doubles as the owner index while a grant is held.
  assign w_owner_req  = i_req[r_ptr];
  assign w_owner_data = i_req_data[int'(r_ptr)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_grant <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_grant <= w_pick;
            r_ptr   <= w_idx;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!w_owner_req) begin
            r_cnt   <= '0;
            r_state <= GAP;
          end else if (!i_tx_busy) begin
            r_start <= 1'b1;
            r_ack   <= r_grant;
            r_data  <= w_owner_data;
            r_last  <= i_req_last[r_ptr];
            r_cnt   <= '0;
            r_state <= WAIT_DONE;
          end
        end
        // A done in the expiry cycle takes precedence over the watchdog.
        WAIT_DONE: begin
          if (i_tx_done) begin
            r_cnt   <= '0;
            r_state <= r_last ? GAP : LOAD;
          end else if (r_cnt == TMO_LAST) begin
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_grant <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ack  = r_ack;
  assign o_grant    = r_grant;
  assign o_tx_start = r_start;
  assign o_tx_data  = r_data;
  assign o_err_tmo  = r_err;
  assign o_active   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: arbitration vector table, directed corner
// sequences and randomized packet traffic against a packet-level model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DATA_W  = 8;
  localparam int GAP_CYC = 40;
  localparam int TMO_CYC = 48;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } byte_t;
  typedef byte_t byteq_t[$];

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
  } arb_vec_t;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic [NREQ-1:0]        i_req = '0;
  logic [NREQ*DATA_W-1:0] i_req_data = '0;
  logic [NREQ-1:0]        i_req_last = '0;
  logic                   i_tx_busy = 1'b0;
  logic                   i_tx_done = 1'b0;
  logic [NREQ-1:0]        o_req_ack;
  logic [NREQ-1:0]        o_grant;
  logic                   o_tx_start;
  logic [DATA_W-1:0]      o_tx_data;
  logic                   o_err_tmo;
  logic                   o_active;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  byteq_t     reqQ[NREQ];
  logic [3:0] enMask = '0;
  bit         suppressDone = 1'b0;
  int         doneLat = 39;
  int         doneCnt = 0;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .CLK_FREQ(40), .BAUD(10),
    .GAP_BITS(10), .TMO_BITS(12)
  ) dut (
    .clk(clk), .nrst(nrst), .i_req(i_req), .i_req_data(i_req_data),
    .i_req_last(i_req_last), .o_req_ack(o_req_ack), .o_grant(o_grant),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .i_tx_done(i_tx_done), .o_err_tmo(o_err_tmo), .o_active(o_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: present the head of each queue, advance on ack.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (o_req_ack[i] && reqQ[i].size() > 0) reqQ[i].delete(0);
      if (enMask[i] && reqQ[i].size() > 0) begin
        i_req[i]                    = 1'b1;
        i_req_data[i*DATA_W +: DATA_W] = reqQ[i][0].data;
        i_req_last[i]               = reqQ[i][0].last;
      end else begin
        i_req[i]                    = 1'b0;
        i_req_data[i*DATA_W +: DATA_W] = '0;
        i_req_last[i]               = 1'b0;
      end
    end
  end

  // Serialiser: done is sampled doneLat+1 edges after the edge launching tx_start.
  always @(negedge clk) begin
    i_tx_done = 1'b0;
    if (!nrst) begin
      doneCnt = 0;
    end else begin
      if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start && !suppressDone) doneCnt = doneLat;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired, wanted the event", name);
  endtask

  task automatic pushByte(input int r, input logic [7:0] d, input logic l);
    byte_t b;
    b.data = d;
    b.last = l;
    reqQ[r].push_back(b);
  endtask

  task automatic doResetSeq();
    nrst = 1'b0;
    i_tx_busy = 1'b0;
    enMask = '0;
    suppressDone = 1'b0;
    doneLat = 39;
    for (int i = 0; i < NREQ; i++) reqQ[i].delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs",
                {13'd0, o_grant, o_req_ack, o_tx_start, o_err_tmo, o_active, o_tx_data}, 32'd0);
    @(negedge clk) nrst = 1'b1;
  endtask

  task automatic waitStart(input int budget, output int s);
    s = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_tx_start) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) failNow("tx_start wait");
  endtask

  task automatic waitGrantZero(input int budget, output int c);
    c = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_err_tmo) checkOutput("stray err_tmo", o_err_tmo, 1'b0);
      if (o_grant == '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) failNow("grant release wait");
  endtask

  // Reference: packet order by round robin from NREQ-1, byte timing from the serialiser latency.
  task automatic runPackets(input int budget);
    exp_t   expQ[$];
    byteq_t mq[NREQ];
    exp_t   e;
    int     ptr = NREQ - 1;
    int     w;
    int     c;
    int     prevS = -1;
    logic   prevLast = 1'b0;
    bit     finished = 1'b0;
    for (int i = 0; i < NREQ; i++) mq[i] = reqQ[i];
    forever begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (ptr + k) % NREQ;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) break;
      ptr = w;
      e.last = 1'b0;
      while (!e.last && mq[w].size() > 0) begin
        e.idx  = w;
        e.data = mq[w][0].data;
        e.last = mq[w][0].last;
        mq[w].delete(0);
        expQ.push_back(e);
      end
    end
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (o_tx_start) begin
        if (expQ.size() == 0) begin
          checkOutput("extra tx_start", o_tx_start, 1'b0);
        end else begin
          e = expQ.pop_front();
          checkOutput("tx_data", o_tx_data, e.data);
          checkOutput("req_ack", o_req_ack, 4'b1 << e.idx);
          checkOutput("grant at start", o_grant, 4'b1 << e.idx);
          if (prevS >= 0)
            checkOutput("start spacing", cyc - prevS,
                        prevLast ? doneLat + 3 + GAP_CYC : doneLat + 2);
          prevS = cyc;
          prevLast = e.last;
        end
      end
      if (o_err_tmo) checkOutput("unexpected err_tmo", o_err_tmo, 1'b0);
      if (expQ.size() == 0 && prevS >= 0 && o_grant == '0) begin
        checkOutput("grant release time", cyc - prevS, doneLat + 1 + GAP_CYC);
        finished = 1'b1;
        break;
      end
    end
    if (!finished) failNow("packet run");
  endtask

  task automatic applyStimulus(input arb_vec_t v);
    int c;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (v.req[i]) pushByte(i, 8'(i), 1'b1);
    enMask = '1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("arb grant", o_grant, v.grant);
    checkOutput("arb active", o_active, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) reqQ[i].delete();
    waitGrantZero(80, c);
  endtask

  initial begin
    arb_vec_t vecs[8];
    int s, c, ec, gz, errs, starts, np, nb, tot;
    vecs[0] = '{4'b1111, 4'b0001};
    vecs[1] = '{4'b1111, 4'b0010};
    vecs[2] = '{4'b1001, 4'b1000};
    vecs[3] = '{4'b1001, 4'b0001};
    vecs[4] = '{4'b0001, 4'b0001};
    vecs[5] = '{4'b0100, 4'b0100};
    vecs[6] = '{4'b0110, 4'b0010};
    vecs[7] = '{4'b1110, 4'b0100};

    // Arbitration table: busy held so owners withdraw from LOAD without sending.
    doResetSeq();
    i_tx_busy = 1'b1;
    for (int k = 0; k < 8; k++) applyStimulus(vecs[k]);
    i_tx_busy = 1'b0;

    // Single requester, three-byte packet.
    doResetSeq();
    pushByte(1, 8'h41, 1'b0);
    pushByte(1, 8'h42, 1'b0);
    pushByte(1, 8'h43, 1'b1);
    enMask = 4'b0010;
    runPackets(500);

    // Full contention right after reset.
    doResetSeq();
    for (int i = 0; i < NREQ; i++) pushByte(i, 8'hA0 + 8'(i), 1'b1);
    enMask = 4'b1111;
    runPackets(800);

    // Lock: requester 2 arrives mid-packet of requester 0.
    doResetSeq();
    pushByte(0, 8'h10, 1'b0);
    pushByte(0, 8'h11, 1'b1);
    pushByte(2, 8'h20, 1'b1);
    enMask = 4'b0001;
    fork
      runPackets(600);
      begin
        c = -1;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (o_req_ack[0]) begin
            c = n;
            break;
          end
        end
        if (c < 0) failNow("lock first ack");
        enMask[2] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("lock grant", o_grant, 4'b0001);
      end
    join

    // Busy hold-off in LOAD.
    doResetSeq();
    i_tx_busy = 1'b1;
    pushByte(3, 8'h5A, 1'b1);
    enMask = 4'b1000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_grant != '0) break;
    end
    checkOutput("busy grant", o_grant, 4'b1000);
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    checkOutput("busy holdoff", starts, 0);
    i_tx_busy = 1'b0;
    @(negedge clk);
    checkOutput("start after busy", o_tx_start, 1'b1);
    checkOutput("busy data", o_tx_data, 8'h5A);
    checkOutput("busy ack", o_req_ack, 4'b1000);
    waitGrantZero(200, c);

    // Watchdog expiry with no tx_done.
    doResetSeq();
    suppressDone = 1'b1;
    pushByte(0, 8'hC3, 1'b1);
    enMask = 4'b0001;
    waitStart(20, s);
    ec = -1;
    gz = -1;
    errs = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (o_err_tmo) begin
        errs++;
        if (ec < 0) ec = cyc;
      end
      if (o_grant == '0) begin
        gz = cyc;
        break;
      end
    end
    checkOutput("err_tmo count", errs, 1);
    checkOutput("err_tmo time", ec - s, TMO_CYC);
    checkOutput("gap after tmo", gz - ec, GAP_CYC);

    // tx_done at the last watchdog cycles: done wins, no error.
    for (int lat = 46; lat <= 47; lat++) begin
      doResetSeq();
      doneLat = lat;
      pushByte(0, 8'h3C, 1'b1);
      enMask = 4'b0001;
      runPackets(300);
    end

    // Asynchronous reset during WAIT_DONE.
    doResetSeq();
    pushByte(2, 8'h77, 1'b0);
    pushByte(2, 8'h78, 1'b1);
    enMask = 4'b0100;
    waitStart(20, s);
    repeat (5) @(negedge clk);
    checkOutput("active before reset", o_active, 1'b1);
    #2 nrst = 1'b0;
    #1;
    checkOutput("async reset outputs",
                {13'd0, o_grant, o_req_ack, o_tx_start, o_err_tmo, o_active, o_tx_data}, 32'd0);
    enMask = '0;
    for (int i = 0; i < NREQ; i++) reqQ[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk);
    #1;
    pushByte(3, 8'h99, 1'b1);
    enMask = 4'b1000;
    @(negedge clk);
    checkOutput("grant before arb", o_grant, 4'b0000);
    @(negedge clk);
    checkOutput("grant after reset", o_grant, 4'b1000);
    waitGrantZero(200, c);

    // Randomized packet traffic.
    repeat (4) begin
      doResetSeq();
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) pushByte(i, 8'($urandom), b == nb - 1);
          tot++;
        end
      end
      if (tot == 0) pushByte($urandom_range(0, NREQ - 1), 8'($urandom), 1'b1);
      enMask = 4'b1111;
      runPackets(4000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one byte-level UART transmitter among NREQ requesters, such as the rx echo buffer, a status reporter and a debug dump. The grant is round-robin at packet granularity: once granted, a requester keeps the transmitter until its byte flagged last has gone out. After every packet the block inserts an idle line gap so the far-end receiver can resynchronise, the same purpose as the 10-bit spacer already used on the echo path. It sits between the requesters and the shared tx serialiser.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
CLK_FREQ, 12000000, clock frequency in Hz
BAUD, 9600, line rate; BIT_CYC = CLK_FREQ/BAUD (1250 at defaults)
GAP_BITS, 10, idle bit-times inserted after each packet
TMO_BITS, 12, watchdog limit in bit-times for one byte to complete

Ports:
clk  in  1  clock
nrst  in  1  reset; asynchronous, active-low
req  in  NREQ  per-requester "byte valid"; held until acked
req_data  in  NREQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W]
req_last  in  NREQ  byte of requester i is the last byte of its packet
req_ack  out  NREQ  one-cycle pulse, byte of requester i accepted
grant  out  NREQ  one-hot owner, or zero when no owner
tx_start  out  1  one-cycle pulse to the serialiser
tx_data  out  DATA_W  byte to send; valid while tx_start=1 and held afterwards
tx_busy  in  1  serialiser is shifting
tx_done  in  1  one-cycle pulse, stop bit finished
err_tmo  out  1  one-cycle pulse, watchdog expired
active  out  1  state is not IDLE

Behaviour:
- Reset values: req_ack=0, grant=0, tx_start=0, tx_data=0, err_tmo=0, active=0. Priority pointer ptr=NREQ-1, so requester 0 wins first. State is IDLE and counters are 0.
- Reset mid-operation drops the grant immediately. Nothing is resumed.
- States: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE:
  - If req is nonzero, choose the first set bit searching ptr+1, ptr+2, … modulo NREQ.
  - Register grant as one-hot for that requester and set ptr to its index. Go to LOAD on the next cycle.
  - There is exactly one cycle of arbitration latency.
- LOAD (owner g):
  - If req[g]=1 and tx_busy=0: assert tx_start=1 and req_ack[g]=1 for one cycle. Load tx_data with the slice for g. Latch last_q=req_last[g]. Clear the watchdog. Go to WAIT_DONE.
  - If req[g]=1 and tx_busy=1: stay in LOAD and issue no start.
  - If req[g]=0 (owner withdrew mid-packet): go to GAP and do not raise an error.
  - Requests from non-owners are ignored until the owner's grant is released.
- WAIT_DONE:
  - On tx_done: if last_q=1 go to GAP, else go to LOAD.
  - The watchdog counts clock cycles. At TMO_BITS*BIT_CYC-1 with no tx_done, pulse err_tmo and go to GAP.
  - If tx_done and watchdog expiry coincide, tx_done wins and err_tmo is not asserted.
- GAP:
  - grant stays held. The counter runs 0 .. GAP_BITS*BIT_CYC-1.
  - At terminal count: grant<=0, go to IDLE.
  - Re-arbitration from ptr gives the fairness rule: the same requester cannot win twice in a row while another is requesting.
- Back-to-back bytes: from tx_done to the next tx_start is exactly 1 cycle (WAIT_DONE→LOAD, start issued in LOAD).
- Counters: cycle counters are 20-bit unsigned and wrap to 0 only at terminal count. Size them with $clog2(TMO_BITS*BIT_CYC); elaboration fails if a count exceeds 2^20.
- A tx_done received outside WAIT_DONE is ignored.
- At most one req_ack bit is ever set, and only in the same cycle as tx_start.

Decomposition:
- Shared package uart_pkg:
  - state enum arb_state_t (IDLE, LOAD, WAIT_DONE, GAP)
  - function bit_cyc(CLK_FREQ, BAUD)
  - constant CNT_W=20
- One sub-module, rr_pick. It is combinational and takes req and ptr, returning a one-hot pick and its index.
- The FSM, counters and datapath mux live in uart_tx_arbiter.

Test Plan:
(All scenarios use CLK_FREQ=40, BAUD=10, so BIT_CYC=4, GAP=40 cycles and TMO=48 cycles. The bench serialiser model pulses tx_done 40 cycles after tx_start.)
1. Single requester: req[1] sends a 3-byte packet 0x41, 0x42, 0x43 with last on 0x43 → three tx_start pulses with matching tx_data, each 41 cycles apart. grant=0b0010 throughout. grant returns to 0 exactly 40 cycles after the third tx_done.
2. Contention after reset: req=0b1111, each requester sending a 1-byte packet → grant order is 0,1,2,3. Each req_ack pulses once, coincident with its tx_start.
3. Lock: req[0] is sending a 2-byte packet; req[2] rises after byte 1 → req[2] is not granted until req[0]'s last byte plus the gap complete. Then grant=0b0100.
4. Busy hold-off: hold tx_busy=1 for 10 cycles while in LOAD → no tx_start until tx_busy falls, then tx_start occurs on the following cycle.
5. Watchdog: suppress tx_done → err_tmo pulses once 48 cycles after tx_start, followed by the 40-cycle gap and then grant=0. Separately, tx_done arriving on cycle 47 produces no err_tmo.
6. Reset mid-packet: assert nrst=0 during WAIT_DONE → all outputs are 0 asynchronously. After release, req=0b1000 is granted in IDLE+1 cycle.
